// File: rtl/execute_stage_buffer.sv
// Elastic decode-to-execute operand buffer: DEPTH-entry first-word-fall-through FIFO
// with valid/ready on both sides, flush, NOP bubble when empty and a saturating stall counter.
module execute_stage_buffer #(
  parameter int XLEN    = 32,
  parameter int CTRL_W  = 16,
  parameter int DEPTH   = 2,
  parameter int STALL_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_data1,
  input  logic [XLEN-1:0]            in_data2,
  input  logic [XLEN-1:0]            in_immediate_data,
  input  logic [CTRL_W-1:0]          in_control,
  input  logic                       in_compflg,
  input  logic [XLEN-1:0]            in_program_counter,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_data1,
  output logic [XLEN-1:0]            out_data2,
  output logic [XLEN-1:0]            out_immediate_data,
  output logic [CTRL_W-1:0]          out_control,
  output logic                       out_compflg,
  output logic [XLEN-1:0]            out_program_counter,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [STALL_W-1:0]         stall_cycles
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BUN_W = 4 * XLEN + CTRL_W + 1;

  logic [BUN_W-1:0] entry_p0 [DEPTH];
  logic [BUN_W-1:0] in_bundle;
  logic [BUN_W-1:0] head_bundle;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Pointers wrap by explicit compare so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(DEPTH - 1)) n = '0;
    else                        n = p + 1'b1;
    return n;
  endfunction

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    logic [STALL_W-1:0] n;
    if (&v) n = v;
    else    n = v + 1'b1;
    return n;
  endfunction

  // in_ready depends only on occupancy, never on out_ready.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign in_bundle = {in_program_counter, in_data1, in_data2,
                      in_immediate_data, in_control, in_compflg};

  always_ff @(posedge clk) begin
    if (push) entry_p0[wr_ptr] <= in_bundle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      stall_cycles <= '0;
    end else begin
      if (in_valid && !in_ready) stall_cycles <= sat_inc(stall_cycles);
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= ptr_next(wr_ptr);
        if (pop)  rd_ptr <= ptr_next(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // An empty buffer presents an all-zero bundle, i.e. a NOP bubble.
  assign head_bundle = out_valid ? entry_p0[rd_ptr] : '0;
  assign {out_program_counter, out_data1, out_data2,
          out_immediate_data, out_control, out_compflg} = head_bundle;

endmodule

// File: tb/tb_execute_stage_buffer.sv
// Bench for execute_stage_buffer: two instances (DEPTH=2/STALL_W=4 and DEPTH=3/STALL_W=16)
// share stimulus and are compared every cycle against queue-based reference models.
module tb_execute_stage_buffer;

  localparam int XLEN = 32;
  localparam int CW   = 16;
  localparam int BW   = 4 * XLEN + CW + 1;
  localparam int D0   = 2;
  localparam int D1   = 3;
  localparam int SMAX0 = 15;
  localparam int SMAX1 = 65535;

  typedef logic [BW-1:0] bun_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [XLEN-1:0] in_data1 = '0, in_data2 = '0, in_imm = '0, in_pc = '0;
  logic [CW-1:0]   in_control = '0;
  logic            in_compflg = 1'b0;

  logic            rdy0, vld0, cf0, rdy1, vld1, cf1;
  logic [XLEN-1:0] d1_0, d2_0, imm0, pc0, d1_1, d2_1, imm1, pc1;
  logic [CW-1:0]   ctl0, ctl1;
  logic [1:0]      cnt0, cnt1;
  logic [3:0]      st0;
  logic [15:0]     st1;

  always #5 clk = ~clk;

  execute_stage_buffer #(.XLEN(XLEN), .CTRL_W(CW), .DEPTH(D0), .STALL_W(4)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_data1(in_data1), .in_data2(in_data2), .in_immediate_data(in_imm),
    .in_control(in_control), .in_compflg(in_compflg), .in_program_counter(in_pc),
    .out_valid(vld0), .out_ready(out_ready), .out_data1(d1_0), .out_data2(d2_0),
    .out_immediate_data(imm0), .out_control(ctl0), .out_compflg(cf0),
    .out_program_counter(pc0), .count(cnt0), .stall_cycles(st0));

  execute_stage_buffer #(.XLEN(XLEN), .CTRL_W(CW), .DEPTH(D1), .STALL_W(16)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_data1(in_data1), .in_data2(in_data2), .in_immediate_data(in_imm),
    .in_control(in_control), .in_compflg(in_compflg), .in_program_counter(in_pc),
    .out_valid(vld1), .out_ready(out_ready), .out_data1(d1_1), .out_data2(d2_1),
    .out_immediate_data(imm1), .out_control(ctl1), .out_compflg(cf1),
    .out_program_counter(pc1), .count(cnt1), .stall_cycles(st1));

  // Reference state: contents of each buffer in arrival order, plus stall counts.
  bun_t q0[$];
  bun_t q1[$];
  int   ms0 = 0;
  int   ms1 = 0;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic bun_t cur_bundle();
    return {in_pc, in_data1, in_data2, in_imm, in_control, in_compflg};
  endfunction

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_edge();
    bit pu0, po0, pu1, po1;
    if (rst) begin
      q0.delete();
      q1.delete();
      ms0 = 0;
      ms1 = 0;
    end else begin
      pu0 = in_valid && (q0.size() < D0);
      po0 = out_ready && (q0.size() != 0);
      pu1 = in_valid && (q1.size() < D1);
      po1 = out_ready && (q1.size() != 0);
      if (in_valid && !(q0.size() < D0) && ms0 < SMAX0) ms0++;
      if (in_valid && !(q1.size() < D1) && ms1 < SMAX1) ms1++;
      if (flush) begin
        q0.delete();
        q1.delete();
      end else begin
        if (po0) void'(q0.pop_front());
        if (pu0) q0.push_back(cur_bundle());
        if (po1) void'(q1.pop_front());
        if (pu1) q1.push_back(cur_bundle());
      end
    end
  endtask

  task automatic compare_all();
    bun_t b0, b1, e0, e1;
    b0 = {pc0, d1_0, d2_0, imm0, ctl0, cf0};
    b1 = {pc1, d1_1, d2_1, imm1, ctl1, cf1};
    e0 = (q0.size() != 0) ? q0[0] : '0;
    e1 = (q1.size() != 0) ? q1[0] : '0;
    check("d2_out_valid", 160'(vld0), 160'(q0.size() != 0));
    check("d2_in_ready",  160'(rdy0), 160'(q0.size() < D0));
    check("d2_count",     160'(cnt0), 160'(q0.size()));
    check("d2_stall",     160'(st0),  160'(ms0));
    check("d2_bundle",    160'(b0),   160'(e0));
    check("d3_out_valid", 160'(vld1), 160'(q1.size() != 0));
    check("d3_in_ready",  160'(rdy1), 160'(q1.size() < D1));
    check("d3_count",     160'(cnt1), 160'(q1.size()));
    check("d3_stall",     160'(st1),  160'(ms1));
    check("d3_bundle",    160'(b1),   160'(e1));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_in(input logic v, input logic [XLEN-1:0] pc);
    in_valid   = v;
    in_pc      = pc;
    in_data1   = $urandom;
    in_data2   = $urandom;
    in_imm     = $urandom;
    in_control = CW'($urandom_range(65535, 1));
    in_compflg = 1'($urandom_range(1));
  endtask

  initial begin
    // Reset then idle
    tick();
    rst = 1'b0;
    tick();
    check("rst_out_valid", 160'(vld0), 160'(0));
    check("rst_out_control", 160'(ctl0), 160'(0));
    check("rst_in_ready", 160'(rdy0), 160'(1));
    check("rst_count", 160'(cnt0), 160'(0));
    check("rst_stall", 160'(st0), 160'(0));

    // Fill with out_ready low, third bundle held while full
    out_ready = 1'b0;
    set_in(1'b1, 32'h100); tick();
    check("fill1_count", 160'(cnt0), 160'(1));
    set_in(1'b1, 32'h104); tick();
    check("fill2_in_ready", 160'(rdy0), 160'(0));
    set_in(1'b1, 32'h108); tick(); tick(); tick();
    check("hold_stall", 160'(st0), 160'(3));
    check("hold_model_size", 160'(q0.size()), 160'(2));
    check("hold_head_pc", 160'(pc0), 160'(32'h100));
    out_ready = 1'b1;
    tick();
    check("drain_pc_104", 160'(pc0), 160'(32'h104));
    check("drain_stall", 160'(st0), 160'(4));
    tick();
    check("drain_pc_108", 160'(pc0), 160'(32'h108));
    set_in(1'b0, 32'h0);
    tick();
    check("drain_empty", 160'(vld0), 160'(0));
    repeat (3) tick();

    // Streaming at one bundle per cycle
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 32'h1000 + 32'(4 * i));
      tick();
    end
    check("stream_count", 160'(cnt0), 160'(1));
    check("stream_last_pc", 160'(pc0), 160'(32'h104c));
    set_in(1'b0, 32'h0);
    repeat (4) tick();

    // Interleaved pushes and pops to exercise pointer wrap
    for (int i = 0; i < 16; i++) begin
      set_in(1'($urandom_range(1)), 32'h300 + 32'(4 * i));
      out_ready = (i % 3) != 0;
      tick();
    end
    set_in(1'b0, 32'h0);
    out_ready = 1'b1;
    repeat (4) tick();

    // Flush with a concurrent push
    out_ready = 1'b0;
    set_in(1'b1, 32'h1f0); tick();
    set_in(1'b1, 32'h1f4); tick();
    check("preflush_count", 160'(cnt0), 160'(2));
    flush = 1'b1;
    set_in(1'b1, 32'h200); tick();
    flush = 1'b0;
    check("flush_count", 160'(cnt0), 160'(0));
    check("flush_valid", 160'(vld0), 160'(0));
    set_in(1'b0, 32'h0); tick();
    check("flush_pc_zero", 160'(pc0), 160'(0));

    // Saturate the 4-bit stall counter, then reset clears it
    set_in(1'b1, 32'h400);
    repeat (22) tick();
    check("sat_stall", 160'(st0), 160'(15));
    check("sat_model", 160'(ms0), 160'(15));
    rst = 1'b1; tick();
    check("rst2_stall", 160'(st0), 160'(0));
    check("rst2_count", 160'(cnt0), 160'(0));
    rst = 1'b0;
    set_in(1'b0, 32'h0);
    tick();

    // Randomised traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      set_in(1'($urandom_range(3) != 0), $urandom);
      out_ready = 1'($urandom_range(2) != 0);
      flush     = ($urandom_range(24) == 0);
      rst       = ($urandom_range(149) == 0);
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
